// File: rtl/id_ex_stage_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : id_ex_stage_if
// Purpose  : Bundles the decode-side handshake, the EX back-pressure and
//            flush controls, the EX/MEM and WB forwarding buses and the
//            ALU-facing outputs of the ID/EX pipeline register.
// Modports : master - the surrounding pipeline (drives in_*, flush,
//                     ex_ready, *_fwd_*; observes in_ready and out_*)
//            slave  - the id_ex_stage register itself
// Revision : 1.0 - initial release
// ============================================================================
interface id_ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 7,
  parameter int REG_W  = 5
);
  // decode side
  logic              in_valid;
  logic [OP_W-1:0]   in_op;
  logic [REG_W-1:0]  in_rs1;
  logic [REG_W-1:0]  in_rs2;
  logic [REG_W-1:0]  in_rd;
  logic [DATA_W-1:0] in_rs1_data;
  logic [DATA_W-1:0] in_rs2_data;
  logic [DATA_W-1:0] in_imm;
  logic              in_use_imm;
  logic              in_ready;
  // control
  logic              flush;
  logic              ex_ready;
  // forwarding sources
  logic              mem_fwd_valid;
  logic [REG_W-1:0]  mem_fwd_rd;
  logic [DATA_W-1:0] mem_fwd_data;
  logic              mem_is_load;
  logic              wb_fwd_valid;
  logic [REG_W-1:0]  wb_fwd_rd;
  logic [DATA_W-1:0] wb_fwd_data;
  // ALU side
  logic              out_valid;
  logic [OP_W-1:0]   out_op;
  logic [DATA_W-1:0] out_x;
  logic [DATA_W-1:0] out_y;
  logic [DATA_W-1:0] out_store_data;
  logic [REG_W-1:0]  out_rd;
  logic              out_is_load;

  modport master (
    output in_valid, in_op, in_rs1, in_rs2, in_rd, in_rs1_data, in_rs2_data,
           in_imm, in_use_imm, flush, ex_ready,
           mem_fwd_valid, mem_fwd_rd, mem_fwd_data, mem_is_load,
           wb_fwd_valid, wb_fwd_rd, wb_fwd_data,
    input  in_ready, out_valid, out_op, out_x, out_y, out_store_data,
           out_rd, out_is_load
  );

  modport slave (
    input  in_valid, in_op, in_rs1, in_rs2, in_rd, in_rs1_data, in_rs2_data,
           in_imm, in_use_imm, flush, ex_ready,
           mem_fwd_valid, mem_fwd_rd, mem_fwd_data, mem_is_load,
           wb_fwd_valid, wb_fwd_rd, wb_fwd_data,
    output in_ready, out_valid, out_op, out_x, out_y, out_store_data,
           out_rd, out_is_load
  );
endinterface
`default_nettype wire

// File: rtl/id_ex_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : id_ex_stage
// Purpose  : Decode/execute pipeline register in front of the ALU. Latches
//            the decoded instruction with its register operands, forwards
//            EX/MEM and WB results onto the ALU x/y inputs, inserts a single
//            bubble on a load-use dependency, holds under EX back-pressure
//            and drops its contents on flush.
// Ports    : clk, reset (synchronous, active high)
//            bus (id_ex_stage_if.slave):
//              in_*            decoded instruction and regfile read data
//              in_ready        stage can accept this cycle
//              flush, ex_ready kill / downstream consume
//              mem_fwd_*, mem_is_load, wb_fwd_*   forwarding sources
//              out_*           ALU op/x/y, store data, dest, load flag
// Revision : 1.0 - initial release
// ============================================================================

// Opcode encodings normally supplied by the shared constants header.
`ifndef ADD
`define ADD      7'd1
`endif
`ifndef SUB
`define SUB      7'd2
`endif
`ifndef MUL
`define MUL      7'd3
`endif
`ifndef LDB
`define LDB      7'd4
`endif
`ifndef LDW
`define LDW      7'd5
`endif
`ifndef STB
`define STB      7'd6
`endif
`ifndef STW
`define STW      7'd7
`endif
`ifndef MOV
`define MOV      7'd8
`endif
`ifndef BEQ
`define BEQ      7'd9
`endif
`ifndef JUMP
`define JUMP     7'd10
`endif
`ifndef TLBWRITE
`define TLBWRITE 7'd11
`endif
`ifndef IRET
`define IRET     7'd12
`endif

module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 7,
  parameter int REG_W  = 5
) (
  input  wire          clk,
  input  wire          reset,
  id_ex_stage_if.slave bus
);

  // Held instruction fields
  logic              r_valid;
  logic [OP_W-1:0]   r_op;
  logic [REG_W-1:0]  r_rs1;
  logic [REG_W-1:0]  r_rs2;
  logic [REG_W-1:0]  r_rd;
  logic [DATA_W-1:0] r_rs1_data;
  logic [DATA_W-1:0] r_rs2_data;
  logic [DATA_W-1:0] r_imm;
  logic              r_use_imm;
  logic              r_is_load;

  logic              w_hazard;
  logic              w_in_is_load;
  logic [DATA_W-1:0] w_cap_rs1_data;
  logic [DATA_W-1:0] w_cap_rs2_data;
  logic [DATA_W-1:0] w_fwd_rs1;
  logic [DATA_W-1:0] w_fwd_rs2;

  // Resolve one source operand: EX/MEM result beats WB result beats the
  // latched register value. A load in EX/MEM has no data yet, so it never
  // forwards (the load-use interlock already kept the consumer back).
  function automatic logic [DATA_W-1:0] resolve(
    input logic [REG_W-1:0]  idx,
    input logic [DATA_W-1:0] latched,
    input logic              mem_v,
    input logic              mem_ld,
    input logic [REG_W-1:0]  mem_rd,
    input logic [DATA_W-1:0] mem_d,
    input logic              wb_v,
    input logic [REG_W-1:0]  wb_rd,
    input logic [DATA_W-1:0] wb_d
  );
    logic [DATA_W-1:0] res;
    res = latched;
    if (idx != '0) begin
      if (mem_v && !mem_ld && (mem_rd == idx))
        res = mem_d;
      else if (wb_v && (wb_rd == idx))
        res = wb_d;
    end
    return res;
  endfunction

  always_comb begin
    w_in_is_load = (bus.in_op == `LDB) || (bus.in_op == `LDW);

    w_hazard = r_valid && r_is_load && bus.in_valid && (r_rd != '0) &&
               ((bus.in_rs1 == r_rd) || (bus.in_rs2 == r_rd));

    // Regfile write and read in the same cycle: take the value being
    // written rather than the stale read data.
    w_cap_rs1_data = bus.in_rs1_data;
    if (bus.wb_fwd_valid && (bus.wb_fwd_rd != '0) && (bus.wb_fwd_rd == bus.in_rs1))
      w_cap_rs1_data = bus.wb_fwd_data;

    w_cap_rs2_data = bus.in_rs2_data;
    if (bus.wb_fwd_valid && (bus.wb_fwd_rd != '0) && (bus.wb_fwd_rd == bus.in_rs2))
      w_cap_rs2_data = bus.wb_fwd_data;

    // Re-evaluated every cycle, including while held under back-pressure.
    w_fwd_rs1 = resolve(r_rs1, r_rs1_data,
                        bus.mem_fwd_valid, bus.mem_is_load, bus.mem_fwd_rd, bus.mem_fwd_data,
                        bus.wb_fwd_valid, bus.wb_fwd_rd, bus.wb_fwd_data);
    w_fwd_rs2 = resolve(r_rs2, r_rs2_data,
                        bus.mem_fwd_valid, bus.mem_is_load, bus.mem_fwd_rd, bus.mem_fwd_data,
                        bus.wb_fwd_valid, bus.wb_fwd_rd, bus.wb_fwd_data);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid    <= 1'b0;
      r_op       <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_use_imm  <= 1'b0;
      r_is_load  <= 1'b0;
    end else if (bus.flush) begin
      r_valid <= 1'b0;
    end else if (r_valid && !bus.ex_ready) begin
      // back-pressure: keep everything
      r_valid <= r_valid;
    end else if (w_hazard) begin
      // load-use bubble; decode keeps presenting the consumer
      r_valid <= 1'b0;
    end else if (bus.in_valid) begin
      r_valid    <= 1'b1;
      r_op       <= bus.in_op;
      r_rs1      <= bus.in_rs1;
      r_rs2      <= bus.in_rs2;
      r_rd       <= bus.in_rd;
      r_rs1_data <= w_cap_rs1_data;
      r_rs2_data <= w_cap_rs2_data;
      r_imm      <= bus.in_imm;
      r_use_imm  <= bus.in_use_imm;
      r_is_load  <= w_in_is_load;
    end else begin
      r_valid <= 1'b0;
    end
  end

  assign bus.in_ready       = !r_valid || (bus.ex_ready && !w_hazard);
  assign bus.out_valid      = r_valid;
  assign bus.out_op         = r_op;
  assign bus.out_rd         = r_rd;
  assign bus.out_is_load    = r_is_load;
  assign bus.out_x          = w_fwd_rs1;
  assign bus.out_y          = r_use_imm ? r_imm : w_fwd_rs2;
  assign bus.out_store_data = w_fwd_rs2;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_stage
// Purpose  : Directed self-checking bench for id_ex_stage: reset, forwarding,
//            load-use bubble, MUL back-pressure, store data, flush and reset.
// Revision : 1.0 - initial release
// ============================================================================
`ifndef ADD
`define ADD      7'd1
`endif
`ifndef SUB
`define SUB      7'd2
`endif
`ifndef MUL
`define MUL      7'd3
`endif
`ifndef LDW
`define LDW      7'd5
`endif
`ifndef STW
`define STW      7'd7
`endif

module tb_id_ex_stage;
  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  id_ex_stage_if bus ();

  id_ex_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one rising edge and settle 1ns past it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid      = 1'b0;
    bus.in_op         = '0;
    bus.in_rs1        = '0;
    bus.in_rs2        = '0;
    bus.in_rd         = '0;
    bus.in_rs1_data   = '0;
    bus.in_rs2_data   = '0;
    bus.in_imm        = '0;
    bus.in_use_imm    = 1'b0;
    bus.flush         = 1'b0;
    bus.ex_ready      = 1'b1;
    bus.mem_fwd_valid = 1'b0;
    bus.mem_fwd_rd    = '0;
    bus.mem_fwd_data  = '0;
    bus.mem_is_load   = 1'b0;
    bus.wb_fwd_valid  = 1'b0;
    bus.wb_fwd_rd     = '0;
    bus.wb_fwd_data   = '0;
  endtask

  task automatic drive_instr(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                             input logic use_imm, input logic [31:0] imm);
    bus.in_valid    = 1'b1;
    bus.in_op       = op;
    bus.in_rs1      = rs1;
    bus.in_rs2      = rs2;
    bus.in_rd       = rd;
    bus.in_rs1_data = d1;
    bus.in_rs2_data = d2;
    bus.in_use_imm  = use_imm;
    bus.in_imm      = imm;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
    n_tests++; if (bus.out_op !== 7'd0) begin n_fail++; $display("FAIL reset_op: got %h want 0", bus.out_op); end
    n_tests++; if (bus.out_rd !== 5'd0) begin n_fail++; $display("FAIL reset_rd: got %h want 0", bus.out_rd); end
    n_tests++; if (bus.out_is_load !== 1'b0) begin n_fail++; $display("FAIL reset_is_load: got %b want 0", bus.out_is_load); end
    n_tests++; if ({bus.out_x, bus.out_y, bus.out_store_data} !== 96'd0) begin n_fail++; $display("FAIL reset_data: got %h/%h/%h want 0", bus.out_x, bus.out_y, bus.out_store_data); end
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    drive_instr(`ADD, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 1'b0, 32'd0);
    step();
    n_tests++; if (bus.out_valid !== 1'b1 || bus.out_op !== `ADD) begin n_fail++; $display("FAIL b2b_add_valid_op: got %b/%h want 1/%h", bus.out_valid, bus.out_op, `ADD); end
    n_tests++; if (bus.out_x !== 32'd5 || bus.out_y !== 32'd7 || bus.out_rd !== 5'd3) begin n_fail++; $display("FAIL b2b_add_xy: got %0d/%0d rd %0d want 5/7 rd 3", bus.out_x, bus.out_y, bus.out_rd); end
    // SUB r4 = r3 - r1, regfile r3 still stale
    drive_instr(`SUB, 5'd3, 5'd1, 5'd4, 32'd0, 32'd5, 1'b0, 32'd0);
    step();
    bus.in_valid      = 1'b0;
    bus.mem_fwd_valid = 1'b1;
    bus.mem_fwd_rd    = 5'd3;
    bus.mem_fwd_data  = 32'd12;
    #1;
    n_tests++; if (bus.out_op !== `SUB) begin n_fail++; $display("FAIL b2b_sub_op: got %h want %h", bus.out_op, `SUB); end
    n_tests++; if (bus.out_x !== 32'd12 || bus.out_y !== 32'd5) begin n_fail++; $display("FAIL b2b_sub_fwd: got x=%0d y=%0d want 12/5", bus.out_x, bus.out_y); end
    // a load in EX/MEM must not forward its (not yet valid) data
    bus.mem_is_load = 1'b1;
    #1;
    n_tests++; if (bus.out_x !== 32'd0) begin n_fail++; $display("FAIL mem_load_no_fwd: got %h want 0", bus.out_x); end
  endtask

  task automatic test_load_use();
    idle_inputs();
    step();
    drive_instr(`LDW, 5'd1, 5'd0, 5'd5, 32'h40, 32'd0, 1'b1, 32'd4);
    step();
    n_tests++; if (bus.out_is_load !== 1'b1 || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL lu_load_held: got is_load=%b valid=%b want 1/1", bus.out_is_load, bus.out_valid); end
    // ADD r6 = r5 + r1 depends on the load
    drive_instr(`ADD, 5'd5, 5'd1, 5'd6, 32'd0, 32'd5, 1'b0, 32'd0);
    #1;
    n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL lu_in_ready_low: got %b want 0", bus.in_ready); end
    step();
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL lu_bubble: got valid=%b want 0", bus.out_valid); end
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL lu_in_ready_back: got %b want 1", bus.in_ready); end
    step();
    bus.in_valid     = 1'b0;
    bus.wb_fwd_valid = 1'b1;
    bus.wb_fwd_rd    = 5'd5;
    bus.wb_fwd_data  = 32'h100;
    #1;
    n_tests++; if (bus.out_valid !== 1'b1 || bus.out_op !== `ADD || bus.out_rd !== 5'd6) begin n_fail++; $display("FAIL lu_capture: got v=%b op=%h rd=%0d want 1/%h/6", bus.out_valid, bus.out_op, bus.out_rd, `ADD); end
    n_tests++; if (bus.out_x !== 32'h100 || bus.out_y !== 32'd5) begin n_fail++; $display("FAIL lu_wb_fwd: got x=%h y=%h want 100/5", bus.out_x, bus.out_y); end
  endtask

  task automatic test_mul_stall();
    idle_inputs();
    step();
    drive_instr(`MUL, 5'd1, 5'd2, 5'd7, 32'd3, 32'd4, 1'b0, 32'd0);
    step();
    bus.ex_ready = 1'b0;
    drive_instr(`ADD, 5'd10, 5'd11, 5'd8, 32'd1, 32'd2, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready[%0d]: got %b want 0", i, bus.in_ready); end
      n_tests++; if (bus.out_valid !== 1'b1 || bus.out_op !== `MUL || bus.out_x !== 32'd3 || bus.out_y !== 32'd4) begin n_fail++; $display("FAIL stall_hold[%0d]: got v=%b op=%h x=%0d y=%0d want 1/%h/3/4", i, bus.out_valid, bus.out_op, bus.out_x, bus.out_y, `MUL); end
      step();
    end
    bus.wb_fwd_valid = 1'b1;
    bus.wb_fwd_rd    = 5'd2;
    bus.wb_fwd_data  = 32'd9;
    #1;
    n_tests++; if (bus.out_y !== 32'd9 || bus.out_x !== 32'd3) begin n_fail++; $display("FAIL stall_fwd: got x=%0d y=%0d want 3/9", bus.out_x, bus.out_y); end
    bus.wb_fwd_valid = 1'b0;
    bus.ex_ready     = 1'b1;
    step();
    n_tests++; if (bus.out_op !== `ADD || bus.out_rd !== 5'd8 || bus.out_x !== 32'd1) begin n_fail++; $display("FAIL stall_release: got op=%h rd=%0d x=%0d want %h/8/1", bus.out_op, bus.out_rd, bus.out_x, `ADD); end
  endtask

  task automatic test_fwd_priority();
    idle_inputs();
    drive_instr(`ADD, 5'd4, 5'd0, 5'd9, 32'h11, 32'h22, 1'b0, 32'd0);
    step();
    bus.in_valid      = 1'b0;
    bus.mem_fwd_valid = 1'b1; bus.mem_fwd_rd = 5'd4; bus.mem_fwd_data = 32'hAA;
    bus.wb_fwd_valid  = 1'b1; bus.wb_fwd_rd  = 5'd4; bus.wb_fwd_data  = 32'hBB;
    #1;
    n_tests++; if (bus.out_x !== 32'hAA) begin n_fail++; $display("FAIL prio_mem_over_wb: got %h want aa", bus.out_x); end
    bus.mem_fwd_valid = 1'b0;
    #1;
    n_tests++; if (bus.out_x !== 32'hBB) begin n_fail++; $display("FAIL prio_wb_only: got %h want bb", bus.out_x); end
    // index 0 is never forwarded
    idle_inputs();
    drive_instr(`ADD, 5'd0, 5'd0, 5'd9, 32'h33, 32'h44, 1'b0, 32'd0);
    step();
    bus.in_valid      = 1'b0;
    bus.mem_fwd_valid = 1'b1; bus.mem_fwd_rd = 5'd0; bus.mem_fwd_data = 32'hAA;
    bus.wb_fwd_valid  = 1'b1; bus.wb_fwd_rd  = 5'd0; bus.wb_fwd_data  = 32'hBB;
    #1;
    n_tests++; if (bus.out_x !== 32'h33 || bus.out_y !== 32'h44) begin n_fail++; $display("FAIL prio_r0: got x=%h y=%h want 33/44", bus.out_x, bus.out_y); end
    // capture-time bypass of a same-cycle WB write
    idle_inputs();
    drive_instr(`ADD, 5'd12, 5'd13, 5'd14, 32'h1, 32'h2, 1'b0, 32'd0);
    bus.wb_fwd_valid = 1'b1; bus.wb_fwd_rd = 5'd12; bus.wb_fwd_data = 32'h77;
    step();
    idle_inputs();
    #1;
    n_tests++; if (bus.out_x !== 32'h77 || bus.out_y !== 32'h2) begin n_fail++; $display("FAIL capture_bypass: got x=%h y=%h want 77/2", bus.out_x, bus.out_y); end
  endtask

  task automatic test_store();
    idle_inputs();
    drive_instr(`STW, 5'd1, 5'd7, 5'd0, 32'h1000, 32'd0, 1'b1, 32'd8);
    step();
    bus.in_valid      = 1'b0;
    bus.mem_fwd_valid = 1'b1; bus.mem_fwd_rd = 5'd7; bus.mem_fwd_data = 32'hDEAD;
    #1;
    n_tests++; if (bus.out_y !== 32'd8 || bus.out_x !== 32'h1000) begin n_fail++; $display("FAIL store_xy: got x=%h y=%h want 1000/8", bus.out_x, bus.out_y); end
    n_tests++; if (bus.out_store_data !== 32'hDEAD) begin n_fail++; $display("FAIL store_data: got %h want dead", bus.out_store_data); end
  endtask

  task automatic test_flush_and_reset();
    idle_inputs();
    drive_instr(`MUL, 5'd1, 5'd2, 5'd7, 32'd3, 32'd4, 1'b0, 32'd0);
    step();
    bus.ex_ready = 1'b0;
    drive_instr(`ADD, 5'd1, 5'd2, 5'd8, 32'd1, 32'd2, 1'b0, 32'd0);
    bus.flush = 1'b1;
    step();
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got valid=%b want 0", bus.out_valid); end
    // reset pulse in the middle of a stall
    idle_inputs();
    drive_instr(`ADD, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 1'b0, 32'd0);
    step();
    bus.ex_ready = 1'b0;
    bus.in_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    n_tests++; if (bus.out_valid !== 1'b0 || bus.out_op !== 7'd0 || bus.out_rd !== 5'd0 || bus.out_is_load !== 1'b0) begin n_fail++; $display("FAIL midreset_ctrl: got v=%b op=%h rd=%0d ld=%b want 0", bus.out_valid, bus.out_op, bus.out_rd, bus.out_is_load); end
    n_tests++; if ({bus.out_x, bus.out_y, bus.out_store_data} !== 96'd0) begin n_fail++; $display("FAIL midreset_data: got %h/%h/%h want 0", bus.out_x, bus.out_y, bus.out_store_data); end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    idle_inputs();
    test_reset();
    test_back_to_back();
    test_load_use();
    test_mul_stall();
    test_fwd_priority();
    test_store();
    test_flush_and_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
